// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART TX and RX sides.
//   - FSM state encoding (IDLE, LOAD, SEND) as localparams and an enum
//   - frame length helper: start bit + payload + stop bit(s)
//   - clog2 helper that never returns a zero width
package uart_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SEND = ST_SEND
    } uart_state_e;

    localparam int START_BITS = 1;

    // Serial bits in one frame: {stop bit(s), data, start bit}
    function automatic int frame_bits(input int data_w, input int stop_bits);
        return START_BITS + data_w + stop_bits;
    endfunction

    // Width needed to hold 0..n-1, at least 1 bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     : per-requester request levels
//   ptr     : index searched first; the search wraps upward from here
//   win     : one-hot winner (all zero when no request)
//   win_idx : index of the winner
//   found   : at least one request is set
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               found
);

    int               j;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        j       = 0;
        cand    = '0;
        // First set bit at or after ptr, modulo NUM_REQ
        for (int k = 0; k < NUM_REQ; k++) begin
            j    = (int'(ptr) + k) % NUM_REQ;
            cand = IDX_W'(j);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        win = found ? (NUM_REQ'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one LSB-first UART TX shift datapath between
// NUM_REQ requesters. Round-robin picks a requester, the payload is handed
// to the datapath with load, and shift strobes are paced by a baud divider.
//   clk, rst   : clock, asynchronous active-high reset
//   tx_enable  : 1 = new frames may be granted (never aborts a running frame)
//   req        : per-requester request level, held until granted
//   req_data   : packed payloads, requester i at [i*DATA_W +: DATA_W]
//   grant      : one-hot pulse, coincides with load
//   load       : datapath captures tx_data
//   tx_data    : payload of the granted requester
//   shift      : datapath advances one bit
//   busy       : frame in progress, load cycle through done cycle
//   owner      : index of the current/last granted requester
//   done       : pulse in the last cycle of a frame
// All outputs are registered.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int IDX_W        = clog2_min1(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      load,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      shift,
    output logic                      busy,
    output logic [IDX_W-1:0]          owner,
    output logic                      done
);

    localparam int FRAME_BITS = frame_bits(DATA_W, STOP_BITS);
    localparam int BAUD_W     = clog2_min1(CLKS_PER_BIT);
    localparam int BIT_W      = clog2_min1(FRAME_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REQ - 1);

    uart_state_e state;

    // ptr holds the index searched first: one past the last grant
    logic [IDX_W-1:0]  ptr;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;

    logic [NUM_REQ-1:0][DATA_W-1:0] data_arr;
    logic [NUM_REQ-1:0]             arb_win;
    logic [IDX_W-1:0]               arb_idx;
    logic                           arb_found;

    assign data_arr = req_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr),
        .win     (arb_win),
        .win_idx (arb_idx),
        .found   (arb_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            grant    <= '0;
            load     <= 1'b0;
            tx_data  <= '0;
            shift    <= 1'b0;
            busy     <= 1'b0;
            owner    <= '0;
            done     <= 1'b0;
        end else begin
            grant <= '0;
            load  <= 1'b0;
            shift <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_enable && arb_found) begin
                        state    <= LOAD;
                        grant    <= arb_win;
                        load     <= 1'b1;
                        tx_data  <= data_arr[arb_idx];
                        owner    <= arb_idx;
                        busy     <= 1'b1;
                        ptr      <= (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                LOAD: begin
                    // The load cycle is the first clock of the start bit, so
                    // the divider is already one count in when SEND begins.
                    // Registered strobes then land exactly on L + n*CLKS_PER_BIT.
                    state    <= SEND;
                    baud_cnt <= BAUD_W'(1);
                end
                SEND: begin
                    if (done) begin
                        // done cycle still counts as busy; arbitration resumes
                        // in the following IDLE cycle
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt != BIT_LAST) begin
                            shift   <= 1'b1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler at default parameters. Expected grants are
// queued when a request is driven and popped by the monitor on each load;
// the monitor also checks strobe timing relative to the load cycle.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 8;
    localparam int CPB        = 16;
    localparam int FRAME_BITS = 10;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      tx_enable;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic                      load;
    logic [DATA_W-1:0]         tx_data;
    logic                      shift;
    logic                      busy;
    logic [1:0]                owner;
    logic                      done;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   nload = 0, nshift = 0, ndone = 0;
    int   last_load = 0, last_done = 0;
    exp_t mon_e;
    logic [3:0] mon_oh;

    uart_tx_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .tx_enable (tx_enable),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .load      (load),
        .tx_data   (tx_data),
        .shift     (shift),
        .busy      (busy),
        .owner     (owner),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        checks++;
        if (shift && done) begin
            errors++;
            $display("FAIL shift_done_overlap cyc=%0d", cyc);
        end
        checks++;
        if ((|grant) !== load || (load && !$onehot(grant))) begin
            errors++;
            $display("FAIL grant_vs_load cyc=%0d grant=%b load=%b", cyc, grant, load);
        end
        if (load) begin
            nload++;
            last_load = cyc;
            nshift = 0;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_load cyc=%0d grant=%b", cyc, grant);
            end else begin
                mon_e  = sb.pop_front();
                mon_oh = 4'b0001 << mon_e.idx;
                if (grant !== mon_oh || tx_data !== mon_e.data || owner !== mon_e.idx || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL load_contents got grant=%b data=%h owner=%0d busy=%b want grant=%b data=%h owner=%0d busy=1",
                             grant, tx_data, owner, busy, mon_oh, mon_e.data, mon_e.idx);
                end
            end
        end
        if (shift) begin
            nshift++;
            checks++;
            if (cyc - last_load !== nshift * CPB || busy !== 1'b1) begin
                errors++;
                $display("FAIL shift_timing n=%0d got offset=%0d busy=%b want offset=%0d busy=1",
                         nshift, cyc - last_load, busy, nshift * CPB);
            end
        end
        if (done) begin
            ndone++;
            last_done = cyc;
            checks++;
            if (cyc - last_load !== FRAME_BITS * CPB || nshift !== FRAME_BITS - 1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL done_timing got offset=%0d shifts=%0d busy=%b want offset=%0d shifts=%0d busy=1",
                         cyc - last_load, nshift, busy, FRAME_BITS * CPB, FRAME_BITS - 1);
            end
        end
    end

    task automatic wait_load(input int target, input int budget, input bit clr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (nload >= target) ok = 1'b1;
        end
        #1;
        if (ok && clr) req[owner] = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (ndone >= target) ok = 1'b1;
        end
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [7:0] d0, d1, d2, d3);
        req_data = {d3, d2, d1, d0};
    endtask

    task automatic test_reset;
        rst = 1'b0; tx_enable = 1'b0; req = '0; req_data = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({load, shift, done, busy} !== 4'b0 || grant !== '0 || owner !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs got load=%b shift=%b done=%b busy=%b grant=%b owner=%0d data=%h want all 0",
                     load, shift, done, busy, grant, owner, tx_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_single;
        int t, d0; bit ok;
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        tx_enable = 1'b1;
        d0 = ndone;
        t = cyc;
        sb.push_back('{2'd2, 8'hA5});
        req = 4'b0100;
        wait_load(nload + 1, 10, 1'b1, ok);
        checks++;
        if (!ok || last_load !== t + 1) begin
            errors++;
            $display("FAIL single_load_latency got ok=%b load_cyc=%0d want %0d", ok, last_load, t + 1);
        end
        wait_done(d0 + 1, 200, ok);
        @(negedge clk);
        checks++;
        if (!ok || busy !== 1'b0 || cyc !== last_done + 1) begin
            errors++;
            $display("FAIL single_busy_release got ok=%b busy=%b cyc=%0d want busy=0 at %0d", ok, busy, cyc, last_done + 1);
        end
        wait_cycles(20);
        checks++;
        if (nload !== 1 || ndone !== d0 + 1) begin
            errors++;
            $display("FAIL single_no_extra got loads=%0d dones=%0d want 1 and %0d", nload, ndone, d0 + 1);
        end
    endtask

    task automatic test_round_robin;
        int prev, n0, d0; bit ok;
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(1);
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        foreach (sb[i]) ;
        sb.push_back('{2'd0, 8'h10});
        sb.push_back('{2'd1, 8'h11});
        sb.push_back('{2'd2, 8'h12});
        sb.push_back('{2'd3, 8'h13});
        sb.push_back('{2'd0, 8'h10});
        n0 = nload;
        d0 = ndone;
        prev = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_load(n0 + k + 1, 200, 1'b0, ok);
            checks++;
            if (!ok || (k > 0 && last_load - prev !== 162)) begin
                errors++;
                $display("FAIL rr_spacing k=%0d got ok=%b gap=%0d want 162", k, ok, last_load - prev);
            end
            prev = last_load;
        end
        req = 4'b0000;
        wait_done(d0 + 5, 200, ok);
        checks++;
        if (!ok || sb.size() !== 0) begin
            errors++;
            $display("FAIL rr_complete got ok=%b pending=%0d want ok=1 pending=0", ok, sb.size());
        end
        wait_cycles(3);
    endtask

    task automatic test_rr_pointer;
        int d0; bit ok;
        set_data(8'h20, 8'h21, 8'h22, 8'h23);
        d0 = ndone;
        // last owner 0 -> lone request 3 makes owner 3
        sb.push_back('{2'd3, 8'h23});
        req = 4'b1000;
        wait_load(nload + 1, 10, 1'b1, ok);
        wait_done(d0 + 1, 200, ok);
        // last owner 3 -> 1001 gives 0 then 3
        sb.push_back('{2'd0, 8'h20});
        sb.push_back('{2'd3, 8'h23});
        req = 4'b1001;
        wait_load(nload + 1, 10, 1'b1, ok);
        wait_load(nload + 1, 200, 1'b1, ok);
        wait_done(d0 + 3, 200, ok);
        // lone request 0 makes owner 0, then 1001 gives 3 then 0
        sb.push_back('{2'd0, 8'h20});
        req = 4'b0001;
        wait_load(nload + 1, 10, 1'b1, ok);
        wait_done(d0 + 4, 200, ok);
        sb.push_back('{2'd3, 8'h23});
        sb.push_back('{2'd0, 8'h20});
        req = 4'b1001;
        wait_load(nload + 1, 10, 1'b1, ok);
        wait_load(nload + 1, 200, 1'b1, ok);
        wait_done(d0 + 6, 200, ok);
        checks++;
        if (!ok || sb.size() !== 0 || req !== 4'b0000) begin
            errors++;
            $display("FAIL rr_pointer_complete got ok=%b pending=%0d req=%b want ok=1 pending=0 req=0000", ok, sb.size(), req);
        end
        wait_cycles(3);
    endtask

    task automatic test_reset_midframe;
        int t, n0, d0; bit ok;
        set_data(8'h30, 8'h31, 8'h32, 8'h33);
        d0 = ndone;
        sb.push_back('{2'd0, 8'h30});
        req = 4'b0001;
        wait_load(nload + 1, 10, 1'b1, ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            if (nshift >= 4) ok = 1'b1;
        end
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || {load, shift, done, busy} !== 4'b0 || grant !== '0 || owner !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL midframe_reset_outputs got ok=%b load=%b shift=%b done=%b busy=%b grant=%b owner=%0d data=%h want all 0",
                     ok, load, shift, done, busy, grant, owner, tx_data);
        end
        wait_cycles(3);
        rst = 1'b0;
        n0 = nload;
        wait_cycles(170);
        checks++;
        if (ndone !== d0 || nshift !== 4 || nload !== n0) begin
            errors++;
            $display("FAIL midframe_no_resume got dones=%0d shifts=%0d loads=%0d want %0d 4 %0d", ndone, nshift, nload, d0, n0);
        end
        t = cyc;
        sb.push_back('{2'd1, 8'h31});
        req = 4'b0010;
        wait_load(nload + 1, 10, 1'b1, ok);
        checks++;
        if (!ok || last_load !== t + 1) begin
            errors++;
            $display("FAIL after_reset_load got ok=%b load_cyc=%0d want %0d", ok, last_load, t + 1);
        end
        wait_done(d0 + 1, 200, ok);
        wait_cycles(3);
    endtask

    task automatic test_enable;
        int t, n0, d0; bit ok;
        set_data(8'h40, 8'h41, 8'h42, 8'h43);
        tx_enable = 1'b0;
        n0 = nload;
        d0 = ndone;
        req = 4'b0001;
        wait_cycles(50);
        checks++;
        if (nload !== n0) begin
            errors++;
            $display("FAIL enable_low_blocks got loads=%0d want %0d", nload, n0);
        end
        t = cyc;
        sb.push_back('{2'd0, 8'h40});
        tx_enable = 1'b1;
        wait_load(n0 + 1, 10, 1'b0, ok);
        checks++;
        if (!ok || last_load !== t + 1) begin
            errors++;
            $display("FAIL enable_rise_load got ok=%b load_cyc=%0d want %0d", ok, last_load, t + 1);
        end
        while (cyc < last_load + 30) begin
            @(posedge clk);
            #1;
        end
        tx_enable = 1'b0;
        wait_done(d0 + 1, 200, ok);
        wait_cycles(20);
        checks++;
        if (!ok || nload !== n0 + 1) begin
            errors++;
            $display("FAIL enable_drop_no_regrant got ok=%b loads=%0d want ok=1 loads=%0d", ok, nload, n0 + 1);
        end
        req = 4'b0000;
        tx_enable = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_pending;
        int n0, d0; bit ok;
        set_data(8'h50, 8'h51, 8'h52, 8'h53);
        n0 = nload;
        d0 = ndone;
        sb.push_back('{2'd0, 8'h50});
        req = 4'b0001;
        wait_load(n0 + 1, 10, 1'b1, ok);
        while (cyc < last_load + 20) begin
            @(posedge clk);
            #1;
        end
        sb.push_back('{2'd2, 8'h52});
        req[2] = 1'b1;
        wait_load(n0 + 2, 200, 1'b1, ok);
        checks++;
        if (!ok || ndone !== d0 + 1 || last_load !== last_done + 2) begin
            errors++;
            $display("FAIL pending_load_time got ok=%b dones=%0d load_cyc=%0d want dones=%0d load_cyc=%0d",
                     ok, ndone, last_load, d0 + 1, last_done + 2);
        end
        wait_done(d0 + 2, 200, ok);
        checks++;
        if (!ok || sb.size() !== 0) begin
            errors++;
            $display("FAIL pending_complete got ok=%b pending=%0d want ok=1 pending=0", ok, sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_rr_pointer;
        test_reset_midframe;
        test_enable;
        test_pending;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
